// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Op codes and FSM state encodings shared by the ALU and decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [7:0] OP_ADD   = 8'd0;
    localparam logic [7:0] OP_ADC   = 8'd1;
    localparam logic [7:0] OP_SUB   = 8'd2;
    localparam logic [7:0] OP_SBC   = 8'd3;
    localparam logic [7:0] OP_OR    = 8'd4;
    localparam logic [7:0] OP_AND   = 8'd5;
    localparam logic [7:0] OP_NOT   = 8'd6;
    localparam logic [7:0] OP_XOR   = 8'd7;
    localparam logic [7:0] OP_CMP   = 8'd8;
    localparam logic [7:0] OP_SHL1  = 8'd12;
    localparam logic [7:0] OP_SHR1  = 8'd13;
    localparam logic [7:0] OP_MULH  = 8'd16;
    localparam logic [7:0] OP_MUL   = 8'd17;
    localparam logic [7:0] OP_MULHU = 8'd18;
    localparam logic [7:0] OP_SHL   = 8'd20;
    localparam logic [7:0] OP_SHR   = 8'd21;
    localparam logic [7:0] OP_ASR   = 8'd22;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MUL   = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    function automatic logic is_mul_op(input logic [7:0] op);
        return (op == OP_MUL) || (op == OP_MULHU);
    endfunction

    function automatic logic is_shift_op(input logic [7:0] op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_comb.sv
`default_nettype none
// ============================================================================
// Module      : alu_comb
// Description : Purely combinational single-cycle ALU operations.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic [7:0]       op,
    output logic [WIDTH-1:0] c,
    output logic             carry_out
);

    localparam int c_half = WIDTH / 2;

    logic [WIDTH:0]   w_a_ext;
    logic [WIDTH:0]   w_b_ext;
    logic [WIDTH:0]   w_cin_ext;
    logic [WIDTH-1:0] w_a_lo;
    logic [WIDTH-1:0] w_b_lo;

    assign w_a_ext   = {1'b0, a};
    assign w_b_ext   = {1'b0, b};
    assign w_cin_ext = {{WIDTH{1'b0}}, carry_in};
    assign w_a_lo    = {{(WIDTH-c_half){1'b0}}, a[c_half-1:0]};
    assign w_b_lo    = {{(WIDTH-c_half){1'b0}}, b[c_half-1:0]};

    // Arithmetic runs at WIDTH+1 bits; bit WIDTH is carry, or borrow for subtraction.
    always_comb begin
        c         = '0;
        carry_out = 1'b0;
        case (op)
            OP_ADD:  {carry_out, c} = w_a_ext + w_b_ext;
            OP_ADC:  {carry_out, c} = w_a_ext + w_b_ext + w_cin_ext;
            OP_SUB:  {carry_out, c} = w_a_ext - w_b_ext;
            OP_SBC:  {carry_out, c} = w_a_ext - w_b_ext - w_cin_ext;
            OP_OR:   c = a | b;
            OP_AND:  c = a & b;
            OP_NOT:  c = ~a;
            OP_XOR:  c = a ^ b;
            OP_CMP: begin
                if (a < b) begin
                    c         = '1;
                    carry_out = 1'b1;
                end else if (a != b) begin
                    c = {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end
            OP_SHL1: begin
                c         = {a[WIDTH-2:0], 1'b0};
                carry_out = a[WIDTH-1];
            end
            OP_SHR1: begin
                c         = {1'b0, a[WIDTH-1:1]};
                carry_out = a[0];
            end
            OP_MULH: c = w_a_lo * w_b_lo;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Handshaked ALU with iterative multiply and variable shifts.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic [7:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             carry_out,
    output logic             is_zero,
    output logic             is_negative
);

    localparam int                SHW            = $clog2(WIDTH);
    localparam logic [SHW:0]      c_mul_cycles   = (SHW+1)'(WIDTH);
    localparam logic [SHW:0]      c_cnt_one      = (SHW+1)'(1);

    logic [1:0]         r_state;
    logic [7:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_sh;
    logic [SHW-1:0]     r_n;
    logic [SHW:0]       r_cnt;
    logic [WIDTH-1:0]   r_c;
    logic               r_carry;

    logic [WIDTH-1:0]   w_comb_c;
    logic               w_comb_carry;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [SHW:0]       w_cnt_next;
    logic [WIDTH-1:0]   w_sh_next;
    logic               w_sh_out;

    alu_comb #(.WIDTH(WIDTH)) u_alu_comb (
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .op        (op),
        .c         (w_comb_c),
        .carry_out (w_comb_carry)
    );

    // Shift-add: the multiplier sits in the low half of the accumulator and is
    // consumed LSB-first while partial products enter the high half.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_a : {WIDTH{1'b0}})};
    assign w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    assign w_cnt_next = r_cnt + c_cnt_one;

    always_comb begin
        w_sh_next = {r_sh[WIDTH-1], r_sh[WIDTH-1:1]};
        w_sh_out  = r_sh[0];
        if (r_op == OP_SHL) begin
            w_sh_next = {r_sh[WIDTH-2:0], 1'b0};
            w_sh_out  = r_sh[WIDTH-1];
        end else if (r_op == OP_SHR) begin
            w_sh_next = {1'b0, r_sh[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_op    <= '0;
            r_a     <= '0;
            r_acc   <= '0;
            r_sh    <= '0;
            r_n     <= '0;
            r_cnt   <= '0;
            r_c     <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op  <= op;
                        r_cnt <= '0;
                        if (is_mul_op(op)) begin
                            r_a     <= a;
                            r_acc   <= {{WIDTH{1'b0}}, b};
                            r_state <= MUL;
                        end else if (is_shift_op(op)) begin
                            if (b[SHW-1:0] == '0) begin
                                r_c     <= a;
                                r_carry <= 1'b0;
                                r_state <= DONE;
                            end else begin
                                r_sh    <= a;
                                r_n     <= b[SHW-1:0];
                                r_state <= SHIFT;
                            end
                        end else begin
                            r_c     <= w_comb_c;
                            r_carry <= w_comb_carry;
                            r_state <= DONE;
                        end
                    end
                end
                MUL: begin
                    r_acc <= w_acc_next;
                    r_cnt <= w_cnt_next;
                    if (w_cnt_next == c_mul_cycles) begin
                        r_c     <= (r_op == OP_MULHU) ? w_acc_next[2*WIDTH-1:WIDTH]
                                                      : w_acc_next[WIDTH-1:0];
                        r_carry <= 1'b0;
                        r_state <= DONE;
                    end
                end
                SHIFT: begin
                    r_sh  <= w_sh_next;
                    r_cnt <= w_cnt_next;
                    if (w_cnt_next == {1'b0, r_n}) begin
                        r_c     <= w_sh_next;
                        r_carry <= w_sh_out;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == DONE);
    assign c           = r_c;
    assign carry_out   = r_carry;
    assign is_zero     = (r_c == '0);
    assign is_negative = r_c[WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed vector bench for alu_seq at WIDTH=32.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] exp_c;
        logic        exp_carry;
        int          exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        carry_in = 1'b0;
    logic [7:0]  op = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] c;
    logic        carry_out;
    logic        is_zero;
    logic        is_negative;

    int n_checks = 0;
    int n_errors = 0;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .carry_in    (carry_in),
        .op          (op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .c           (c),
        .carry_out   (carry_out),
        .is_zero     (is_zero),
        .is_negative (is_negative)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge with the DUT idle; junk is driven after accept.
    task automatic run_op(input vec_t v, input int idx);
        int lat;
        op = v.op; a = v.a; b = v.b; carry_in = v.cin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 8'($urandom); a = $urandom; b = $urandom; carry_in = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("v%0d_lat", idx), 64'(lat), 64'(v.exp_lat));
        chk($sformatf("v%0d_c", idx), 64'(c), 64'(v.exp_c));
        chk($sformatf("v%0d_carry", idx), 64'(carry_out), 64'(v.exp_carry));
        chk($sformatf("v%0d_zero", idx), 64'(is_zero), 64'(v.exp_c == 32'h0));
        chk($sformatf("v%0d_neg", idx), 64'(is_negative), 64'(v.exp_c[31]));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk($sformatf("v%0d_idle", idx), 64'({out_valid, in_ready}), 64'(2'b01));
    endtask

    vec_t vecs[$];
    vec_t v;

    initial begin
        vecs.push_back('{OP_ADD,   32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1});
        vecs.push_back('{OP_ADC,   32'h00000005, 32'h00000007, 1'b1, 32'h0000000D, 1'b0, 1});
        vecs.push_back('{OP_SUB,   32'h00000003, 32'h00000005, 1'b0, 32'hFFFFFFFE, 1'b1, 1});
        vecs.push_back('{OP_SBC,   32'h00000010, 32'h00000003, 1'b1, 32'h0000000C, 1'b0, 1});
        vecs.push_back('{OP_OR,    32'hF0F000FF, 32'h0F0F0F00, 1'b0, 32'hFFFF0FFF, 1'b0, 1});
        vecs.push_back('{OP_AND,   32'hF0F000FF, 32'h0F0F0F00, 1'b0, 32'h00000000, 1'b0, 1});
        vecs.push_back('{OP_NOT,   32'h12345678, 32'h00000000, 1'b0, 32'hEDCBA987, 1'b0, 1});
        vecs.push_back('{OP_XOR,   32'hFFFF0000, 32'h0F0F0F0F, 1'b0, 32'hF0F00F0F, 1'b0, 1});
        vecs.push_back('{OP_CMP,   32'h00000003, 32'h00000005, 1'b0, 32'hFFFFFFFF, 1'b1, 1});
        vecs.push_back('{OP_CMP,   32'h00000007, 32'h00000007, 1'b0, 32'h00000000, 1'b0, 1});
        vecs.push_back('{OP_CMP,   32'h00000009, 32'h00000002, 1'b0, 32'h00000001, 1'b0, 1});
        vecs.push_back('{OP_SHL1,  32'h80000001, 32'h00000000, 1'b0, 32'h00000002, 1'b1, 1});
        vecs.push_back('{OP_SHR1,  32'h80000001, 32'h00000000, 1'b0, 32'h40000000, 1'b1, 1});
        vecs.push_back('{OP_MULH,  32'h12340003, 32'h56780005, 1'b0, 32'h0000000F, 1'b0, 1});
        vecs.push_back('{OP_MULH,  32'h0000FFFF, 32'h0000FFFF, 1'b0, 32'hFFFE0001, 1'b0, 1});
        vecs.push_back('{8'd9,     32'h12345678, 32'h9ABCDEF0, 1'b1, 32'h00000000, 1'b0, 1});
        vecs.push_back('{8'd255,   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b0, 1});
        vecs.push_back('{OP_MUL,   32'h00010003, 32'h00020005, 1'b0, 32'h000B000F, 1'b0, 33});
        vecs.push_back('{OP_MULHU, 32'h00010003, 32'h00020005, 1'b0, 32'h00000002, 1'b0, 33});
        vecs.push_back('{OP_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000001, 1'b0, 33});
        vecs.push_back('{OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b0, 33});
        vecs.push_back('{OP_ASR,   32'h80000000, 32'h00000004, 1'b0, 32'hF8000000, 1'b0, 5});
        vecs.push_back('{OP_ASR,   32'h80000000, 32'h00000000, 1'b0, 32'h80000000, 1'b0, 1});
        vecs.push_back('{OP_ASR,   32'h40000000, 32'h00000003, 1'b0, 32'h08000000, 1'b0, 4});
        vecs.push_back('{OP_SHL,   32'h00000001, 32'h0000001F, 1'b0, 32'h80000000, 1'b0, 32});
        vecs.push_back('{OP_SHL,   32'hC0000000, 32'h00000001, 1'b0, 32'h80000000, 1'b1, 2});
        vecs.push_back('{OP_SHR,   32'h00000003, 32'h00000002, 1'b0, 32'h00000000, 1'b1, 3});
        vecs.push_back('{OP_SHR,   32'hFFFFFFFF, 32'h00000025, 1'b0, 32'h07FFFFFF, 1'b1, 6});

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_handshake", 64'({in_ready, out_valid}), 64'(2'b10));
        chk("rst_c", 64'(c), 64'h0);
        chk("rst_flags", 64'({carry_out, is_zero, is_negative}), 64'(3'b010));
        resetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) run_op(vecs[i], i);

        // Result held while the consumer stalls; a pending request waits for handoff.
        op = OP_ADD; a = 32'h1; b = 32'h2; carry_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        op = OP_XOR; a = 32'hFF00FF00; b = 32'h0F0F0F0F;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("hold%0d_c", k), 64'({c, carry_out, is_zero, is_negative}),
                64'({32'h3, 3'b000}));
            chk($sformatf("hold%0d_hs", k), 64'({out_valid, in_ready}), 64'(2'b10));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("handoff_no_accept", 64'({out_valid, in_ready}), 64'(2'b01));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("after_handoff_accept", 64'({out_valid, c}), 64'({1'b1, 32'hF00FF00F}));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in the middle of a multiply aborts it.
        op = OP_MUL; a = 32'h00010003; b = 32'h00020005; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk("abort_hs", 64'({out_valid, in_ready}), 64'(2'b01));
        chk("abort_c", 64'({c, carry_out, is_zero}), 64'({32'h0, 2'b01}));
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        v = '{OP_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1};
        run_op(v, 99);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
